// File: rtl/up_loader_ctrl.sv
// up_loader_ctrl: buffers a 256-byte program image from a valid/ready byte
// stream, replays it to up_core's serial load port (byte 255 first), then
// paces the core's active-low interrupt with a periodic pulse while in RUN.
module up_loader_ctrl #(
   parameter int INT_PERIOD = 100,
   parameter int INT_LOW    = 50,
   parameter bit INT_EN     = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       core_load,
   output logic [7:0] core_mem,
   output logic       core_int,
   output logic       busy,
   output logic       done
);

   localparam int            CW       = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(INT_PERIOD - 1);
   localparam logic [CW-1:0] LOW_FROM = CW'(INT_PERIOD - INT_LOW);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_PREP,
      S_STREAM,
      S_RUN
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    wr_ptr_q, wr_ptr_d;
   logic [8:0]    rd_cnt_q, rd_cnt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          in_ready_q, in_ready_d;
   logic          core_load_q, core_load_d;
   logic [7:0]    core_mem_q, core_mem_d;
   logic          core_int_q, core_int_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [7:0]    img_mem [0:255];
   logic [7:0]    rd_data_q;
   logic [7:0]    rd_addr;
   logic          wr_en;
   logic [CW-1:0] cnt_inc;
   logic          in_busy_state;

   // Buffer control: write on handshake, read address runs one byte ahead
   // of the byte being presented so the registered read is always ready.
   always_comb begin
      wr_en         = (state_q == S_FILL) && in_valid && in_ready_q;
      rd_addr       = (state_q == S_PREP) ? 8'hFF : (8'd254 - rd_cnt_q[7:0]);
      cnt_inc       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      in_busy_state = (state_q == S_FILL) || (state_q == S_PREP) ||
                      (state_q == S_STREAM);
   end

   // Image buffer with synchronous write and registered read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         img_mem[wr_ptr_q] <= in_data;
      end
      rd_data_q <= img_mem[rd_addr];
   end

   // Next-state and next-output logic; abort is applied last so it wins.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_cnt_d    = rd_cnt_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      core_load_d = core_load_q;
      core_mem_d  = core_mem_q;
      core_int_d  = core_int_q;
      busy_d      = busy_q;
      done_d      = done_q;

      case (state_q)
         S_IDLE, S_RUN: begin
            if (state_q == S_RUN) begin
               cnt_d      = cnt_inc;
               core_int_d = ~(INT_EN & (cnt_inc >= LOW_FROM));
            end
            if (start) begin
               state_d    = S_FILL;
               wr_ptr_d   = '0;
               rd_cnt_d   = '0;
               cnt_d      = '0;
               in_ready_d = 1'b1;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               core_int_d = 1'b1;
            end
         end
         S_FILL: begin
            if (wr_en) begin
               wr_ptr_d = wr_ptr_q + 8'd1;
               if (wr_ptr_q == 8'hFF) begin
                  state_d    = S_PREP;
                  in_ready_d = 1'b0;
               end
            end
         end
         S_PREP: begin
            state_d  = S_STREAM;
            rd_cnt_d = '0;
         end
         S_STREAM: begin
            if (rd_cnt_q[8]) begin
               state_d     = S_RUN;
               core_load_d = 1'b0;
               core_mem_d  = '0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               cnt_d       = '0;
               core_int_d  = 1'b1;
            end else begin
               core_load_d = 1'b1;
               core_mem_d  = rd_data_q;
               rd_cnt_d    = rd_cnt_q + 9'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort && in_busy_state) begin
         state_d     = S_IDLE;
         in_ready_d  = 1'b0;
         core_load_d = 1'b0;
         core_mem_d  = '0;
         busy_d      = 1'b0;
         done_d      = 1'b0;
         core_int_d  = 1'b1;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_cnt_q    <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         core_load_q <= 1'b0;
         core_mem_q  <= '0;
         core_int_q  <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_cnt_q    <= rd_cnt_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         core_load_q <= core_load_d;
         core_mem_q  <= core_mem_d;
         core_int_q  <= core_int_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign core_load = core_load_q;
   assign core_mem  = core_mem_q;
   assign core_int  = core_int_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
